bram_port_arbiter: RTL

- Shares one port of the dual-port `bram` between two requesters, for example CPU data access and a display/IO reader.
- Arbitration is round-robin with a bounded burst length.
- The block drives the BRAM port combinationally from the winning requester and returns read data one cycle later, tagged by per-requester valid strobes.
- It sits between the requesters and a single `bram` port (address/data/write-enable/output data).

---
 rtl/bram_port_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port between two requesters, with a
// bounded burst length and per-requester read-valid strobes one cycle after grant.
module bram_port_arbiter #(
    parameter int P_DATA_WIDTH    = 16,
    parameter int P_ADDRESS_WIDTH = 10,
    parameter int P_MAX_BURST     = 4
) (
    input  logic                       I_CLK,
    input  logic                       I_NRESET,
    input  logic                       I_REQ_0,
    input  logic                       I_WRITE_ENABLE_0,
    input  logic [P_ADDRESS_WIDTH-1:0] I_ADDRESS_0,
    input  logic [P_DATA_WIDTH-1:0]    I_DATA_0,
    output logic                       O_GRANT_0,
    output logic                       O_DATA_VALID_0,
    input  logic                       I_REQ_1,
    input  logic                       I_WRITE_ENABLE_1,
    input  logic [P_ADDRESS_WIDTH-1:0] I_ADDRESS_1,
    input  logic [P_DATA_WIDTH-1:0]    I_DATA_1,
    output logic                       O_GRANT_1,
    output logic                       O_DATA_VALID_1,
    output logic [P_DATA_WIDTH-1:0]    O_READ_DATA,
    output logic [P_ADDRESS_WIDTH-1:0] O_BRAM_ADDRESS,
    output logic [P_DATA_WIDTH-1:0]    O_BRAM_DATA,
    output logic                       O_BRAM_WRITE_ENABLE,
    input  logic [P_DATA_WIDTH-1:0]    I_BRAM_DATA
);

    localparam int              LP_BW  = $clog2(P_MAX_BURST + 1);
    localparam logic [LP_BW-1:0] LP_MAX = LP_BW'(P_MAX_BURST);

    logic                       last_grant;
    logic [LP_BW-1:0]           burst_count;
    logic                       rd_pend_0;
    logic                       rd_pend_1;
    logic [P_ADDRESS_WIDTH-1:0] addr_hold;

    logic grant_0;
    logic grant_1;
    logic last_req;
    logic keep;

    // Under contention the previous winner keeps the port only while its burst is unexhausted.
    always_comb begin
        grant_0  = 1'b0;
        grant_1  = 1'b0;
        last_req = last_grant ? I_REQ_1 : I_REQ_0;
        keep     = (burst_count != '0) && last_req && (burst_count < LP_MAX);
        if (I_NRESET) begin
            if (I_REQ_0 && I_REQ_1) begin
                if (keep) begin
                    grant_0 = ~last_grant;
                    grant_1 = last_grant;
                end else begin
                    grant_0 = last_grant;
                    grant_1 = ~last_grant;
                end
            end else begin
                grant_0 = I_REQ_0;
                grant_1 = I_REQ_1;
            end
        end
    end

    always_comb begin
        O_BRAM_WRITE_ENABLE = 1'b0;
        O_BRAM_ADDRESS      = addr_hold;
        O_BRAM_DATA         = '0;
        if (grant_0) begin
            O_BRAM_WRITE_ENABLE = I_WRITE_ENABLE_0;
            O_BRAM_ADDRESS      = I_ADDRESS_0;
            O_BRAM_DATA         = I_DATA_0;
        end else if (grant_1) begin
            O_BRAM_WRITE_ENABLE = I_WRITE_ENABLE_1;
            O_BRAM_ADDRESS      = I_ADDRESS_1;
            O_BRAM_DATA         = I_DATA_1;
        end
    end

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            last_grant  <= 1'b1;
            burst_count <= '0;
            rd_pend_0   <= 1'b0;
            rd_pend_1   <= 1'b0;
            addr_hold   <= '0;
        end else begin
            if (grant_0 || grant_1) begin
                if ((grant_1 == last_grant) && (burst_count != '0)) begin
                    if (burst_count < LP_MAX) begin
                        burst_count <= burst_count + 1'b1;
                    end
                end else begin
                    last_grant  <= grant_1;
                    burst_count <= LP_BW'(1);
                end
                addr_hold <= O_BRAM_ADDRESS;
            end else begin
                burst_count <= '0;
            end
            rd_pend_0 <= grant_0 & ~I_WRITE_ENABLE_0;
            rd_pend_1 <= grant_1 & ~I_WRITE_ENABLE_1;
        end
    end

    assign O_GRANT_0      = grant_0;
    assign O_GRANT_1      = grant_1;
    assign O_DATA_VALID_0 = rd_pend_0;
    assign O_DATA_VALID_1 = rd_pend_1;
    assign O_READ_DATA    = I_BRAM_DATA;

endmodule
